// File: rtl/fetch_mem_responder.sv
// Slow byte-wide memory responder for fetch/store handshakes, with a fixed number of wait states.
// Define MEM_WPROT_EN to write-protect addresses below PROT_LIMIT.
module fetch_mem_responder #(
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned PROT_LIMIT  = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FETCH,
  input  logic          STORE_MEM,
  input  logic [AW-1:0] ADDR,
  input  logic [7:0]    DIN,
  output logic [7:0]    DOUT,
  output logic          READY,
  output logic          BUSY,
  output logic          ERR,
  output logic [1:0]    STATE
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  localparam int unsigned DW    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10,
    S_ILL  = 2'b11
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_store;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  logic [DW-1:0]   r_dout;
  logic            r_ready;
  logic            r_busy;
  logic            r_err;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_req;
  logic            w_accept;
  logic            w_commit;
  logic            w_c_store;
  logic [AW-1:0]   w_c_addr;
  logic [DW-1:0]   w_c_din;
  logic            w_prot;
  logic            w_err;

  // With zero wait states the access is performed on the acceptance edge, straight from the inputs.
  always_comb begin
    w_req     = FETCH || STORE_MEM;
    w_accept  = (r_state == S_IDLE) && w_req;
    w_commit  = ((r_state == S_WAIT) && (r_cnt == CW'(1))) ||
                ((WAIT_CYCLES == 0) && w_accept);
    w_c_store = (r_state == S_IDLE) ? STORE_MEM : r_store;
    w_c_addr  = (r_state == S_IDLE) ? ADDR      : r_addr;
    w_c_din   = (r_state == S_IDLE) ? DIN       : r_din;
`ifdef MEM_WPROT_EN
    w_prot    = w_c_store && ((PROT_LIMIT >= DEPTH) || (w_c_addr < AW'(PROT_LIMIT)));
`else
    // PROT_LIMIT only matters when write protection is built in.
    w_prot    = 1'b0 & (PROT_LIMIT == 0);
`endif
    w_err     = (w_req && ((r_state != S_IDLE) || (FETCH && STORE_MEM))) ||
                (w_commit && w_prot);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_store <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= w_err;

      // Memory access happens on the edge that enters RESP.
      if (w_commit) begin
        if (w_c_store) begin
          if (!w_prot) r_mem[w_c_addr] <= w_c_din;
        end else begin
          r_dout <= r_mem[w_c_addr];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_store <= STORE_MEM;
            r_addr  <= ADDR;
            r_din   <= DIN;
            r_cnt   <= CW'(WAIT_CYCLES);
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DOUT  = r_dout;
  assign READY = r_ready;
  assign BUSY  = r_busy;
  assign ERR   = r_err;
  assign STATE = r_state;

endmodule
